// File: rtl/mux_16bit_pkg.sv
// Shared constants for the registered 2:1 word multiplexer.
// Select encodings name which data input a select value picks.
package mux_16bit_pkg;

  localparam int   MUX_DEFAULT_WIDTH = 16;
  localparam logic MUX_SEL_IN0       = 1'b0;
  localparam logic MUX_SEL_IN1       = 1'b1;

endpackage : mux_16bit_pkg

// File: rtl/mux_16bit_mux2_comb.sv
// Purely combinational WIDTH-bit 2:1 selector feeding the output register.
// An unknown select propagates as X in simulation instead of picking a side.
module mux2_comb
  import mux_16bit_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             select,
  output logic [WIDTH-1:0] sel_data
);

  always_comb begin
    sel_data = 'x;
    case (select)
      MUX_SEL_IN0: sel_data = in0;
      MUX_SEL_IN1: sel_data = in1;
      default:     sel_data = 'x;
    endcase
  end

endmodule : mux2_comb

// File: rtl/mux_16bit.sv
// Registered 2:1 word multiplexer: one combinational select stage followed by
// an output register with capture enable and a one-cycle valid flag.
module mux_16bit
  import mux_16bit_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;

  mux2_comb #(
    .WIDTH(WIDTH)
  ) u_mux2_comb (
    .in0     (in0),
    .in1     (in1),
    .select  (select),
    .sel_data(sel_data)
  );

  // Reset beats enable; a disabled edge holds the word but drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out       <= sel_data;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && en) begin
      assert (!$isunknown(select))
        else $error("mux_16bit: unknown select while capture enabled");
    end
  end
`endif

endmodule : mux_16bit

// File: tb/tb_mux_16bit.sv
// Directed self-checking bench for mux_16bit with hand-computed expectations.
module tb_mux_16bit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         select;
  logic [W-1:0] out;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  mux_16bit #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in0      (in0),
    .in1      (in1),
    .select   (select),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic r, input logic e, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic s);
    rst    = r;
    en     = e;
    in0    = a;
    in1    = b;
    select = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] exp_out,
                             input logic exp_valid);
    checks++;
    assert (out === exp_out)
      else begin
        errors++;
        $error("[TB] FAIL %s out: got %h expected %h", tag, out, exp_out);
      end
    checks++;
    assert (out_valid === exp_valid)
      else begin
        errors++;
        $error("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
      end
  endtask

  initial begin
    logic s;
    logic e;
    rst = 1'b1; en = 1'b0; in0 = '0; in1 = '0; select = 1'b0;
    #2;

    $display("[TB] reset with enable held high");
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    checkOutput("reset_c1", 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    checkOutput("reset_c2", 16'h0000, 1'b0);

    $display("[TB] select in0 then in1");
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h000F, 1'b0);
    checkOutput("sel_in0", 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h000F, 1'b1);
    checkOutput("sel_in1", 16'h000F, 1'b1);

    $display("[TB] full-width alternation");
    for (int i = 0; i < 4; i++) begin
      s = (i % 2) == 1;
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, s);
      checkOutput($sformatf("full_width_%0d", i), s ? 16'h0000 : 16'hFFFF, 1'b1);
    end

    $display("[TB] hold with enable low");
    applyStimulus(1'b0, 1'b1, 16'hA5A5, 16'h0000, 1'b0);
    checkOutput("hold_capture", 16'hA5A5, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1);
    checkOutput("hold_c1", 16'hA5A5, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h3333, 16'h4444, 1'b0);
    checkOutput("hold_c2", 16'hA5A5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1);
    checkOutput("hold_release", 16'h2222, 1'b1);

    $display("[TB] reset priority over enable");
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h5555, 1'b1);
    checkOutput("rst_priority", 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h5555, 1'b1);
    checkOutput("after_rst", 16'h5555, 1'b1);

    $display("[TB] equal inputs with random select");
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      e = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(1'b0, e, 16'h3C3C, 16'h3C3C, s);
      checkOutput($sformatf("equal_%0d", i), 16'h3C3C, e);
    end

    $display("[TB] mid-stream reset discards word");
    applyStimulus(1'b1, 1'b1, 16'h7E7E, 16'h0101, 1'b0);
    checkOutput("final_rst", 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_16bit

// File: doc/mux_16bit.md
# mux_16bit

Registered, parameterized 2:1 word multiplexer with a default width of 16 bits. It forwards one of two data words to a registered output, chosen by a single select bit. It is a datapath building block that sits in front of register-file write ports and ALU operand paths. The output register decouples the downstream logic from the combinational select path.

## Interface
Parameters:
- WIDTH, 16, data width of in0, in1 and out (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  capture enable; when low, the output register holds its value.
- in0  input  WIDTH  data word chosen when select = 0.
- in1  input  WIDTH  data word chosen when select = 1.
- select  input  1  source choice: 0 = in0, 1 = in1.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  high for each cycle after a capture (en = 1 while not in reset); low otherwise.

## Operation
- Combinational stage: sel_data = select ? in1 : in0, computed bitwise across all WIDTH bits.
- There is no arithmetic and no width conversion. Inputs and output share the same WIDTH.
- Narrower values driven by an integrating bench are zero-extended by the bench before they reach the port. The block itself never extends or truncates data.
- Register stage, evaluated at each rising clk edge, in priority order:
  - rst = 1: out <= 0 and out_valid <= 0.
  - else en = 1: out <= sel_data and out_valid <= 1.
  - else: out holds its value and out_valid <= 0.
- X or Z on select must not be resolved optimistically. A simulation-only assertion flags an unknown select whenever en = 1.
- in0 == in1: out equals that value regardless of select.

## Timing
- Latency is one cycle. The inputs sampled at edge N appear on out after edge N.
- Throughput is one new word per cycle. There is no backpressure.
- Reset state: out = 0 and out_valid = 0, taking effect at the first rising edge with rst high.
- Reset wins over en when both are high in the same cycle.
- Asserting rst during a stream discards the word presented in that cycle.
- Changing select between edges has no effect on out until the next enabled edge.
- No combinational path exists from any input to out or out_valid.

## Structure
- The shared package holds:
  - the constant MUX_DEFAULT_WIDTH = 16;
  - the constant MUX_SEL_IN0 = 1'b0;
  - the constant MUX_SEL_IN1 = 1'b1.
- The sub-module mux2_comb is a purely combinational WIDTH-parameterized 2:1 selector. It is instantiated once and followed by the output register in the top-level module.
- The unknown-select assertion sits in the top-level module, inside a simulation-only guard.

## Test plan
- Reset: rst = 1 for 2 cycles with in0 = 0x1234, in1 = 0xABCD, en = 1 -> out = 0x0000 and out_valid = 0 throughout.
- Select in0: in0 = 0x0000, in1 = 0x000F, select = 0, en = 1 -> next cycle out = 0x0000 and out_valid = 1. Then hold in1 = 0x000F and set in0 = 0x0000, select = 1 -> next cycle out = 0x000F.
- Full width: in0 = 0xFFFF, in1 = 0x0000, select toggles every cycle -> out alternates 0xFFFF/0x0000, lagging select by one cycle.
- Hold: capture 0xA5A5, then drop en and change in0, in1 and select -> out stays 0xA5A5 and out_valid = 0 until en returns.
- Reset priority: rst = 1 and en = 1 in the same cycle with in1 = 0x5555, select = 1 -> out = 0x0000.
- Equal inputs: in0 = in1 = 0x3C3C with select random over 20 cycles -> out = 0x3C3C on every enabled cycle.
